// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard sources from the 5-stage core and the stall/flush controls returned to it.
// master = core side driving hazard info; slave = hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_RS1;
    logic [4:0]       ID_RS2;
    logic             ID_RS1_used;
    logic             ID_RS2_used;
    logic [4:0]       EX_RD;
    logic             EX_MemRead;
    logic             EX_BrTaken;
    logic             I_MISS;
    logic             I_READY;
    logic             D_REQ;
    logic             D_MISS;
    logic             D_READY;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Write;
    logic             ID_EX_Flush;
    logic             EX_MEM_Write;
    logic             MEM_WB_Bubble;
    logic [1:0]       STATE;
    logic [CNT_W-1:0] STALL_CYCLES;
    logic             TIMEOUT;

    modport master (
        output ID_RS1, ID_RS2, ID_RS1_used, ID_RS2_used, EX_RD, EX_MemRead, EX_BrTaken,
               I_MISS, I_READY, D_REQ, D_MISS, D_READY,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write,
               MEM_WB_Bubble, STATE, STALL_CYCLES, TIMEOUT
    );

    modport slave (
        input  ID_RS1, ID_RS2, ID_RS1_used, ID_RS2_used, EX_RD, EX_MemRead, EX_BrTaken,
               I_MISS, I_READY, D_REQ, D_MISS, D_READY,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write,
               MEM_WB_Bubble, STATE, STALL_CYCLES, TIMEOUT
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush scheduler with cache-miss hold FSM, stall counter and miss timeout.
// Latency: zero-cycle (Mealy) control response; the FSM holds the pipe across multi-cycle misses.
module pipe_hazard_ctrl #(
    parameter int CNT_W        = 32,
    parameter int MISS_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RSTn,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_IMISS  = 2'd1,
        ST_DMISS  = 2'd2,
        ST_IDRAIN = 2'd3
    } state_t;

    localparam int            TW     = $clog2(MISS_TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX  = TW'(MISS_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(MISS_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             i_pend, i_pend_nxt;
    logic [TW-1:0]    tcnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             timeout;

    logic load_use, dmiss, freeze;
    logic pc_wr, ifid_wr, ifid_fl, idex_wr, idex_fl, exmem_wr, memwb_bub;

    assign load_use = hz.EX_MemRead && (hz.EX_RD != 5'd0) &&
                      ((hz.ID_RS1_used && (hz.ID_RS1 == hz.EX_RD)) ||
                       (hz.ID_RS2_used && (hz.ID_RS2 == hz.EX_RD)));
    assign dmiss    = hz.D_REQ && hz.D_MISS;

    always_comb begin
        state_nxt  = state;
        i_pend_nxt = i_pend;
        freeze     = 1'b0;
        pc_wr      = 1'b1;
        ifid_wr    = 1'b1;
        ifid_fl    = 1'b0;
        idex_wr    = 1'b1;
        idex_fl    = 1'b0;
        exmem_wr   = 1'b1;
        memwb_bub  = 1'b0;

        case (state)
            ST_RUN: begin
                if (dmiss) begin
                    freeze    = 1'b1;
                    state_nxt = ST_DMISS;
                end else if (hz.EX_BrTaken) begin
                    ifid_fl = 1'b1;
                    idex_fl = 1'b1;
                end else if (load_use) begin
                    pc_wr   = 1'b0;
                    ifid_wr = 1'b0;
                    idex_fl = 1'b1;
                end else if (hz.I_MISS) begin
                    pc_wr     = 1'b0;
                    ifid_fl   = 1'b1;
                    state_nxt = ST_IMISS;
                end
            end

            ST_IMISS: begin
                pc_wr   = 1'b0;
                ifid_fl = 1'b1;
                if (dmiss) begin
                    freeze     = 1'b1;
                    i_pend_nxt = 1'b1;
                    state_nxt  = ST_DMISS;
                end else if (hz.EX_BrTaken && !hz.I_READY) begin
                    // The outstanding fill is for the wrong path; drain it before refetching.
                    pc_wr     = 1'b1;
                    idex_fl   = 1'b1;
                    state_nxt = ST_IDRAIN;
                end else if (hz.I_READY) begin
                    state_nxt = ST_RUN;
                    pc_wr     = 1'b1;
                    ifid_fl   = 1'b0;
                    if (hz.EX_BrTaken) begin
                        ifid_fl = 1'b1;
                        idex_fl = 1'b1;
                    end else if (load_use) begin
                        pc_wr   = 1'b0;
                        ifid_wr = 1'b0;
                        idex_fl = 1'b1;
                    end
                end
            end

            ST_DMISS: begin
                freeze = 1'b1;
                if (hz.I_READY)
                    i_pend_nxt = 1'b0;
                if (hz.D_READY) begin
                    freeze     = 1'b0;
                    i_pend_nxt = 1'b0;
                    state_nxt  = ST_RUN;
                    if (hz.EX_BrTaken) begin
                        ifid_fl = 1'b1;
                        idex_fl = 1'b1;
                    end else begin
                        if (i_pend && !hz.I_READY) begin
                            // Fetch miss is still outstanding: resume holding the front end.
                            pc_wr     = 1'b0;
                            ifid_fl   = 1'b1;
                            state_nxt = ST_IMISS;
                        end
                        if (load_use) begin
                            pc_wr   = 1'b0;
                            ifid_wr = 1'b0;
                            ifid_fl = 1'b0;
                            idex_fl = 1'b1;
                        end
                    end
                end
            end

            ST_IDRAIN: begin
                pc_wr   = 1'b0;
                ifid_fl = 1'b1;
                if (dmiss) begin
                    freeze     = 1'b1;
                    i_pend_nxt = 1'b1;
                    state_nxt  = ST_DMISS;
                end else if (hz.I_READY) begin
                    state_nxt = ST_RUN;
                end
            end

            default: state_nxt = ST_RUN;
        endcase

        if (freeze) begin
            pc_wr     = 1'b0;
            ifid_wr   = 1'b0;
            ifid_fl   = 1'b0;
            idex_wr   = 1'b0;
            idex_fl   = 1'b0;
            exmem_wr  = 1'b0;
            memwb_bub = 1'b1;
        end

        if (!RSTn) begin
            pc_wr     = 1'b0;
            ifid_wr   = 1'b0;
            ifid_fl   = 1'b1;
            idex_wr   = 1'b0;
            idex_fl   = 1'b1;
            exmem_wr  = 1'b0;
            memwb_bub = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= ST_RUN;
            i_pend    <= 1'b0;
            tcnt      <= '0;
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            state  <= state_nxt;
            i_pend <= i_pend_nxt;
            if (state == ST_RUN)
                tcnt <= '0;
            else if (tcnt != T_MAX)
                tcnt <= tcnt + TW'(1);
            // Sticky: the FSM keeps waiting, software inspects the flag.
            if ((state != ST_RUN) && (tcnt >= T_LAST))
                timeout <= 1'b1;
            if (!pc_wr && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign hz.PC_Write      = pc_wr;
    assign hz.IF_ID_Write   = ifid_wr;
    assign hz.IF_ID_Flush   = ifid_fl;
    assign hz.ID_EX_Write   = idex_wr;
    assign hz.ID_EX_Flush   = idex_fl;
    assign hz.EX_MEM_Write  = exmem_wr;
    assign hz.MEM_WB_Bubble = memwb_bub;
    assign hz.STATE         = state;
    assign hz.STALL_CYCLES  = stall_cnt;
    assign hz.TIMEOUT       = timeout;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; control vector = {PC_W, IFID_W, IFID_F, IDEX_W, IDEX_F, EXMEM_W, MEMWB_B}.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [6:0] C_RST = 7'b0010101;
    localparam logic [6:0] C_DEF = 7'b1101010;
    localparam logic [6:0] C_FRZ = 7'b0000001;
    localparam logic [6:0] C_BR  = 7'b1111110;
    localparam logic [6:0] C_LU  = 7'b0001110;
    localparam logic [6:0] C_IM  = 7'b0111010;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(32)) hz();

    pipe_hazard_ctrl #(.CNT_W(32), .MISS_TIMEOUT(8)) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .hz   (hz)
    );

    function automatic logic [6:0] ctl();
        return {hz.PC_Write, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Write,
                hz.ID_EX_Flush, hz.EX_MEM_Write, hz.MEM_WB_Bubble};
    endfunction

    task automatic clear_inputs();
        hz.ID_RS1 = 5'd0; hz.ID_RS2 = 5'd0; hz.ID_RS1_used = 1'b0; hz.ID_RS2_used = 1'b0;
        hz.EX_RD = 5'd0; hz.EX_MemRead = 1'b0; hz.EX_BrTaken = 1'b0;
        hz.I_MISS = 1'b0; hz.I_READY = 1'b0;
        hz.D_REQ = 1'b0; hz.D_MISS = 1'b0; hz.D_READY = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (ctl() !== C_RST) $display("FAIL rst_ctl got %b exp %b", ctl(), C_RST); else n_pass++;
        n_checks++; if ({hz.STATE, hz.TIMEOUT} !== 3'b000 || hz.STALL_CYCLES !== 32'd0)
            $display("FAIL rst_regs got st=%0d to=%0d sc=%0d exp 0/0/0", hz.STATE, hz.TIMEOUT, hz.STALL_CYCLES);
        else n_pass++;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl() !== C_DEF) $display("FAIL idle_ctl got %b exp %b", ctl(), C_DEF); else n_pass++;
        next_cycle();
        n_checks++; if (hz.STALL_CYCLES !== 32'd0) $display("FAIL idle_stall got %0d exp 0", hz.STALL_CYCLES); else n_pass++;
    endtask

    task automatic test_load_use();
        apply_reset();
        hz.EX_MemRead = 1'b1; hz.EX_RD = 5'd5; hz.ID_RS2 = 5'd5; hz.ID_RS2_used = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl() !== C_LU) $display("FAIL lu_rs2_ctl got %b exp %b", ctl(), C_LU); else n_pass++;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++; if (ctl() !== C_DEF) $display("FAIL lu_after_ctl got %b exp %b", ctl(), C_DEF); else n_pass++;
        n_checks++; if (hz.STALL_CYCLES !== 32'd1) $display("FAIL lu_stall got %0d exp 1", hz.STALL_CYCLES); else n_pass++;
        // rd = x0 never creates a dependency
        hz.EX_MemRead = 1'b1; hz.EX_RD = 5'd0; hz.ID_RS2 = 5'd0; hz.ID_RS2_used = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl() !== C_DEF) $display("FAIL lu_x0_ctl got %b exp %b", ctl(), C_DEF); else n_pass++;
        next_cycle();
        hz.EX_MemRead = 1'b1; hz.EX_RD = 5'd7; hz.ID_RS1 = 5'd7; hz.ID_RS1_used = 1'b0; hz.ID_RS2_used = 1'b0;
        @(negedge clk);
        n_checks++; if (ctl() !== C_DEF) $display("FAIL lu_unused_ctl got %b exp %b", ctl(), C_DEF); else n_pass++;
        next_cycle();
        hz.ID_RS1_used = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl() !== C_LU) $display("FAIL lu_rs1_ctl got %b exp %b", ctl(), C_LU); else n_pass++;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++; if (hz.STALL_CYCLES !== 32'd2) $display("FAIL lu_stall2 got %0d exp 2", hz.STALL_CYCLES); else n_pass++;
    endtask

    task automatic test_dmiss();
        int bad = 0;
        apply_reset();
        hz.D_REQ = 1'b1; hz.D_MISS = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl() !== C_FRZ) $display("FAIL dm_entry_ctl got %b exp %b", ctl(), C_FRZ); else n_pass++;
        next_cycle();
        clear_inputs();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ctl() !== C_FRZ || hz.STATE !== 2'd2) bad++;
            next_cycle();
        end
        n_checks++; if (bad != 0) $display("FAIL dm_hold got %0d bad cycles exp 0", bad); else n_pass++;
        hz.D_READY = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl() !== C_DEF || hz.STATE !== 2'd2)
            $display("FAIL dm_release got ctl=%b st=%0d exp %b st=2", ctl(), hz.STATE, C_DEF); else n_pass++;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++; if (hz.STATE !== 2'd0) $display("FAIL dm_exit_state got %0d exp 0", hz.STATE); else n_pass++;
        n_checks++; if (hz.STALL_CYCLES !== 32'd11) $display("FAIL dm_stall got %0d exp 11", hz.STALL_CYCLES); else n_pass++;
    endtask

    task automatic test_imiss_dmiss(input logic with_iready);
        logic [1:0] exp_st;
        apply_reset();
        hz.I_MISS = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl() !== C_IM) $display("FAIL id%0d_imiss_ctl got %b exp %b", with_iready, ctl(), C_IM); else n_pass++;
        next_cycle();
        next_cycle();
        hz.I_MISS = 1'b0; hz.D_REQ = 1'b1; hz.D_MISS = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl() !== C_FRZ || hz.STATE !== 2'd1)
            $display("FAIL id%0d_dm_in_im got ctl=%b st=%0d exp %b st=1", with_iready, ctl(), hz.STATE, C_FRZ); else n_pass++;
        next_cycle();
        clear_inputs();
        hz.I_READY = with_iready;
        @(negedge clk);
        n_checks++; if (ctl() !== C_FRZ || hz.STATE !== 2'd2)
            $display("FAIL id%0d_dm_hold got ctl=%b st=%0d exp %b st=2", with_iready, ctl(), hz.STATE, C_FRZ); else n_pass++;
        next_cycle();
        hz.I_READY = 1'b0;
        next_cycle();
        hz.D_READY = 1'b1;
        next_cycle();
        hz.D_READY = 1'b0;
        exp_st = with_iready ? 2'd0 : 2'd1;
        @(negedge clk);
        n_checks++; if (hz.STATE !== exp_st) $display("FAIL id%0d_after_dready got %0d exp %0d", with_iready, hz.STATE, exp_st); else n_pass++;
        hz.I_READY = !with_iready;
        next_cycle();
        hz.I_READY = 1'b0;
        @(negedge clk);
        n_checks++; if (hz.STATE !== 2'd0) $display("FAIL id%0d_final got %0d exp 0", with_iready, hz.STATE); else n_pass++;
    endtask

    task automatic test_imiss_branch();
        apply_reset();
        hz.I_MISS = 1'b1;
        next_cycle();
        hz.I_MISS = 1'b0; hz.EX_BrTaken = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl() !== C_BR || hz.STATE !== 2'd1)
            $display("FAIL ib_redirect got ctl=%b st=%0d exp %b st=1", ctl(), hz.STATE, C_BR); else n_pass++;
        next_cycle();
        hz.EX_BrTaken = 1'b0;
        @(negedge clk);
        n_checks++; if (ctl() !== C_IM || hz.STATE !== 2'd3)
            $display("FAIL ib_drain got ctl=%b st=%0d exp %b st=3", ctl(), hz.STATE, C_IM); else n_pass++;
        next_cycle();
        next_cycle();
        next_cycle();
        hz.I_READY = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl() !== C_IM || hz.STATE !== 2'd3)
            $display("FAIL ib_fill_drop got ctl=%b st=%0d exp %b st=3", ctl(), hz.STATE, C_IM); else n_pass++;
        next_cycle();
        hz.I_READY = 1'b0;
        @(negedge clk);
        n_checks++; if (ctl() !== C_DEF || hz.STATE !== 2'd0)
            $display("FAIL ib_refetch got ctl=%b st=%0d exp %b st=0", ctl(), hz.STATE, C_DEF); else n_pass++;
        n_checks++; if (hz.STALL_CYCLES !== 32'd5) $display("FAIL ib_stall got %0d exp 5", hz.STALL_CYCLES); else n_pass++;
    endtask

    task automatic test_priority();
        apply_reset();
        hz.EX_BrTaken = 1'b1; hz.EX_MemRead = 1'b1; hz.EX_RD = 5'd9; hz.ID_RS1 = 5'd9; hz.ID_RS1_used = 1'b1;
        hz.I_MISS = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl() !== C_BR) $display("FAIL pr_br_over_lu got %b exp %b", ctl(), C_BR); else n_pass++;
        next_cycle();
        hz.D_REQ = 1'b1; hz.D_MISS = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl() !== C_FRZ) $display("FAIL pr_dm_over_br got %b exp %b", ctl(), C_FRZ); else n_pass++;
        next_cycle();
        clear_inputs();
        hz.D_READY = 1'b1;
        @(negedge clk);
        n_checks++; if (hz.STATE !== 2'd2 || hz.STALL_CYCLES !== 32'd1)
            $display("FAIL pr_dmiss got st=%0d sc=%0d exp st=2 sc=1", hz.STATE, hz.STALL_CYCLES); else n_pass++;
        next_cycle();
        hz.D_READY = 1'b1; hz.I_READY = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl() !== C_DEF || hz.STATE !== 2'd0)
            $display("FAIL pr_spurious got ctl=%b st=%0d exp %b st=0", ctl(), hz.STATE, C_DEF); else n_pass++;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++; if (hz.STATE !== 2'd0) $display("FAIL pr_spurious_state got %0d exp 0", hz.STATE); else n_pass++;
    endtask

    task automatic test_timeout_reset();
        apply_reset();
        hz.D_REQ = 1'b1; hz.D_MISS = 1'b1;
        next_cycle();
        clear_inputs();
        for (int k = 1; k < 8; k++) next_cycle();
        @(negedge clk);
        n_checks++; if (hz.TIMEOUT !== 1'b0) $display("FAIL to_early got %0d exp 0", hz.TIMEOUT); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++; if (hz.TIMEOUT !== 1'b1 || hz.STATE !== 2'd2)
            $display("FAIL to_set got to=%0d st=%0d exp to=1 st=2", hz.TIMEOUT, hz.STATE); else n_pass++;
        n_checks++; if (hz.STALL_CYCLES !== 32'd9) $display("FAIL to_stall got %0d exp 9", hz.STALL_CYCLES); else n_pass++;
        next_cycle();
        rst_n = 1'b0;
        #1;
        n_checks++; if (hz.STATE !== 2'd0 || hz.TIMEOUT !== 1'b0 || hz.STALL_CYCLES !== 32'd0)
            $display("FAIL to_async_rst got st=%0d to=%0d sc=%0d exp 0/0/0", hz.STATE, hz.TIMEOUT, hz.STALL_CYCLES);
        else n_pass++;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl() !== C_DEF || hz.STATE !== 2'd0)
            $display("FAIL to_after_rst got ctl=%b st=%0d exp %b st=0", ctl(), hz.STATE, C_DEF); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dmiss();
        test_imiss_dmiss(1'b1);
        test_imiss_dmiss(1'b0);
        test_imiss_branch();
        test_priority();
        test_timeout_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
